// File: rtl/adder_share_pkg.sv
// Shared types and default sizes for the adder-sharing controller.
package adder_share_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        HOLD  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] id,
    output logic           any
);

    always_comb begin
        int unsigned idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        // Walk offsets from farthest to nearest so the nearest hit overwrites.
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one 2-cycle-latency adder unit among N requesters: round-robin grant,
// operand hold across the unit's sampling window, tagged response with timeout.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = DEF_N,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           dp_start,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    input  logic [W-1:0]   dp_y,
    input  logic           dp_valid,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  count;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic           take;
    logic           wait_done;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .id    (gnt_id),
        .any   (gnt_any)
    );

    // Handshake: a requester's operands are taken on a cycle where its
    // req_valid and req_ready are both high; a response is consumed on a cycle
    // where rsp_valid and rsp_ready are both high. req_ready is only offered
    // in IDLE, so a grant can never coincide with a response handshake.
    assign req_ready = (state == IDLE) ? gnt : '0;
    assign take      = (state == IDLE) && gnt_any;
    assign wait_done = dp_valid || (count == CNT_LAST);
    assign dp_start  = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_any) state_nx = ISSUE;
            ISSUE:   state_nx = HOLD;
            HOLD:    state_nx = WAIT;
            WAIT:    if (wait_done) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            count    <= '0;
            dp_a     <= '0;
            dp_b     <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            // dp_a/dp_b double as the operand latch; they change only on a grant.
            if (take) begin
                dp_a   <= req_a[gnt_id*W +: W];
                dp_b   <= req_b[gnt_id*W +: W];
                rsp_id <= gnt_id;
                rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
            end
            if (state == HOLD) begin
                count <= '0;
            end
            if (state == WAIT) begin
                if (dp_valid) begin
                    rsp_data <= dp_y;
                    rsp_err  <= 1'b0;
                end else if (count == CNT_LAST) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed plus randomized bench for adder_share_ctrl, with a behavioural
// adder unit and a round-robin/arithmetic reference model.
module tb_adder_share_ctrl;

    localparam int W       = 8;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           dp_start;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic [W-1:0]   dp_y;
    logic           dp_valid;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    adder_share_ctrl #(.W(W), .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_y      (dp_y),
        .dp_valid  (dp_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // behavioural adder unit: a at start, b one cycle later, result 2 cycles after start
    logic         mute  = 1'b0;
    logic         s1    = 1'b0;
    logic         mv    = 1'b0;
    logic [W-1:0] m_a   = '0;
    logic [W-1:0] my    = '0;
    logic         inj_v = 1'b0;
    logic [W-1:0] inj_y = '0;

    always @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            mv <= 1'b0;
        end else begin
            s1 <= dp_start;
            if (dp_start) m_a <= dp_a;
            mv <= s1 && !mute;
            if (s1) my <= m_a + dp_b;
        end
    end

    assign dp_valid = mv | inj_v;
    assign dp_y     = inj_v ? inj_y : my;

    // reference model
    function automatic int rr_pick(input logic [N-1:0] mask, input int p);
        for (int off = 0; off < N; off++) begin
            if (mask[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    endtask

    // driver: one full transaction from request to response handshake
    task automatic run_txn(input logic [N-1:0] mask, input int bp, input logic mute_i);
        int           gid;
        int           cyc;
        int           lat;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ed;
        mute      = mute_i;
        req_valid = mask;
        pack_ops();
        #1;
        gid = rr_pick(mask, ptr_m);
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("grant", 32'(req_ready), 32'(1) << gid);
        ptr_m = (gid + 1) % N;
        ea  = op_a[gid];
        eb  = op_b[gid];
        ed  = mute_i ? '0 : W'(int'(ea) + int'(eb));
        lat = mute_i ? 3 + TIMEOUT : 4;

        @(negedge clk);
        chk("issue_start", 32'(dp_start), 1);
        chk("issue_a", 32'(dp_a), 32'(ea));
        chk("issue_b", 32'(dp_b), 32'(eb));
        chk("issue_busy", 32'(busy), 1);
        chk("issue_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("hold_start", 32'(dp_start), 0);
        chk("hold_b", 32'(dp_b), 32'(eb));
        cyc = 2;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", 32'(cyc), 32'(lat));
        chk("rsp_id", 32'(rsp_id), 32'(gid));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_err", 32'(rsp_err), 32'(mute_i));
        chk("a_held", 32'(dp_a), 32'(ea));
        for (int k = 0; k < bp; k++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 32'(gid));
            chk("bp_data", 32'(rsp_data), 32'(ed));
            chk("bp_err", 32'(rsp_err), 32'(mute_i));
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pack_ops();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_dp_start", 32'(dp_start), 0);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_dp_b", 32'(dp_b), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        // single request
        op_a[0] = 8'h12;
        op_b[0] = 8'h34;
        run_txn(4'b0001, 0, 1'b0);

        // reset during WAIT abandons the operation and clears the pointer
        mute      = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'h4);
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_start", 32'(dp_start), 0);
        ptr_m = 0;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("mid_no_rsp", 32'(seen), 0);
        mute = 1'b0;

        // round robin with everyone asserting continuously
        for (int i = 0; i < N; i++) begin
            op_a[i] = 8'(8'h10 * (i + 1));
            op_b[i] = 8'(i + 3);
        end
        for (int t = 0; t < 5; t++) run_txn(4'b1111, 0, 1'b0);

        // wrap-around sum on requester 1 (leaves pointer at 2)
        op_a[1] = 8'hF0;
        op_b[1] = 8'h20;
        run_txn(4'b0010, 0, 1'b0);

        // only 0 and 3 valid with pointer at 2: 3 then 0
        run_txn(4'b1001, 0, 1'b0);
        run_txn(4'b1001, 0, 1'b0);

        // backpressure for 6 cycles
        op_a[2] = 8'h7F;
        op_b[2] = 8'h01;
        run_txn(4'b0100, 6, 1'b0);

        // timeout, then a normal transaction
        run_txn(4'b1000, 2, 1'b1);
        run_txn(4'b1000, 0, 1'b0);

        // stray dp_valid while idle is ignored
        req_valid = '0;
        inj_y     = 8'h55;
        inj_v     = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        @(negedge clk);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_valid", 32'(rsp_valid), 0);
        run_txn(4'b0001, 0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = W'($urandom);
                op_b[i] = W'($urandom);
            end
            run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
